// File: rtl/uart_operand_ctrl.sv
// uart_operand_ctrl: sequences the UART <-> CPU operand/result data path.
// The RX side collects two bytes and writes each into the ID-stage register file through the
// shared write port, yielding to WB. It then raises an interrupt to IF.
// The TX side holds one result byte and launches it on the UART transmitter.
module uart_operand_ctrl #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // UART receiver
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  // Register-file write port shared with WB
  input  logic              wb_busy_i,
  output logic              uart_signal_o,
  output logic              uart_flag_o,
  output logic [DATA_W-1:0] uart_rx_data_o,
  // Interrupt handshake with the CPU
  output logic              irq_o,
  input  logic              int_ack_i,
  // Result byte from the CPU to the UART transmitter
  input  logic              result_valid_i,
  input  logic [DATA_W-1:0] result_data_i,
  input  logic              tx_ready_i,
  output logic              tx_start_o,
  output logic [DATA_W-1:0] tx_data_o,
  // Sticky error flags, cleared by int_ack
  output logic              rx_overrun_o,
  output logic              tx_drop_o
);

  typedef enum logic [2:0] {
    StWaitOp1,
    StPendOp1,
    StWaitOp2,
    StPendOp2,
    StIrq
  } rx_state_e;

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rx_overrun_q, rx_overrun_d;
  logic              tx_drop_q, tx_drop_d;
  logic              tx_full_q, tx_full_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;

  logic              rx_drop;
  logic              tx_drop_evt;
  logic              tx_start;
  logic              uart_signal;
  logic              uart_flag;

  // RX sequencer: next state, operand hold register, timeout counter and write strobe.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    rx_drop     = 1'b0;
    uart_signal = 1'b0;
    uart_flag   = 1'b0;
    case (state_q)
      StWaitOp1: begin
        if (rx_valid_i) begin
          hold_d  = rx_data_i;
          state_d = StPendOp1;
        end
      end
      StPendOp1: begin
        // WB owns the write port whenever it is busy; we just retry next cycle.
        uart_signal = !wb_busy_i;
        rx_drop     = rx_valid_i;
        if (!wb_busy_i) begin
          state_d = StWaitOp2;
          cnt_d   = '0;
        end
      end
      StWaitOp2: begin
        cnt_d = cnt_q + 1'b1;
        // A byte arriving on the last timeout cycle still counts as operand2.
        if (rx_valid_i) begin
          hold_d  = rx_data_i;
          state_d = StPendOp2;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StWaitOp1;
        end
      end
      StPendOp2: begin
        uart_signal = !wb_busy_i;
        uart_flag   = 1'b1;
        rx_drop     = rx_valid_i;
        if (!wb_busy_i) begin
          state_d = StIrq;
        end
      end
      StIrq: begin
        if (int_ack_i) begin
          // The ack frees the sequencer, so a byte in the same cycle starts a new pair.
          if (rx_valid_i) begin
            hold_d  = rx_data_i;
            state_d = StPendOp1;
          end else begin
            state_d = StWaitOp1;
          end
        end else begin
          rx_drop = rx_valid_i;
        end
      end
      default: begin
        state_d = StWaitOp1;
      end
    endcase
  end

  // Single-entry TX buffer; a slot freed by tx_start can be refilled in the same cycle.
  always_comb begin
    tx_start    = tx_full_q & tx_ready_i;
    tx_full_d   = tx_full_q;
    tx_data_d   = tx_data_q;
    tx_drop_evt = 1'b0;
    if (result_valid_i && (!tx_full_q || tx_start)) begin
      tx_data_d = result_data_i;
      tx_full_d = 1'b1;
    end else begin
      if (tx_start) begin
        tx_full_d = 1'b0;
      end
      tx_drop_evt = result_valid_i;
    end
  end

  // Sticky error flags: a set event in the same cycle beats the int_ack clear.
  always_comb begin
    rx_overrun_d = rx_overrun_q;
    tx_drop_d    = tx_drop_q;
    if (int_ack_i) begin
      rx_overrun_d = 1'b0;
      tx_drop_d    = 1'b0;
    end
    if (rx_drop) begin
      rx_overrun_d = 1'b1;
    end
    if (tx_drop_evt) begin
      tx_drop_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StWaitOp1;
      hold_q       <= '0;
      cnt_q        <= '0;
      rx_overrun_q <= 1'b0;
      tx_drop_q    <= 1'b0;
      tx_full_q    <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      rx_overrun_q <= rx_overrun_d;
      tx_drop_q    <= tx_drop_d;
      tx_full_q    <= tx_full_d;
      tx_data_q    <= tx_data_d;
    end
  end

  // Output drive.
  always_comb begin
    uart_signal_o  = uart_signal;
    uart_flag_o    = uart_flag;
    uart_rx_data_o = hold_q;
    irq_o          = (state_q == StIrq);
    tx_start_o     = tx_start;
    tx_data_o      = tx_data_q;
    rx_overrun_o   = rx_overrun_q;
    tx_drop_o      = tx_drop_q;
  end

endmodule

// File: tb/tb_uart_operand_ctrl.sv
// Directed self-checking bench for uart_operand_ctrl (TIMEOUT_CYC shortened to 8).
module tb_uart_operand_ctrl;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          wb_busy;
  logic          uart_signal;
  logic          uart_flag;
  logic [DW-1:0] uart_rx_data;
  logic          irq;
  logic          int_ack;
  logic          result_valid;
  logic [DW-1:0] result_data;
  logic          tx_ready;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          rx_overrun;
  logic          tx_drop;

  int checks = 0;
  int errors = 0;

  uart_operand_ctrl #(
    .DATA_W     (DW),
    .TIMEOUT_CYC(8),
    .CNT_W      (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rx_valid_i    (rx_valid),
    .rx_data_i     (rx_data),
    .wb_busy_i     (wb_busy),
    .uart_signal_o (uart_signal),
    .uart_flag_o   (uart_flag),
    .uart_rx_data_o(uart_rx_data),
    .irq_o         (irq),
    .int_ack_i     (int_ack),
    .result_valid_i(result_valid),
    .result_data_i (result_data),
    .tx_ready_i    (tx_ready),
    .tx_start_o    (tx_start),
    .tx_data_o     (tx_data),
    .rx_overrun_o  (rx_overrun),
    .tx_drop_o     (tx_drop)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs driven afterwards are sampled at the next edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; wb_busy = 1'b0; int_ack = 1'b0;
    result_valid = 1'b0; result_data = '0; tx_ready = 1'b0;
    cyc(); cyc();
    checks++;
    if ({uart_signal, uart_flag, irq, tx_start, rx_overrun, tx_drop} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {uart_signal, uart_flag, irq, tx_start, rx_overrun, tx_drop});
    end
    checks++;
    if (uart_rx_data !== 8'h00 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h/%h want 00/00", uart_rx_data, tx_data);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    rx_valid = 1'b1; rx_data = 8'h12;
    cyc();
    rx_valid = 1'b0; #1;
    checks++;
    if ({uart_signal, uart_flag, uart_rx_data} !== {2'b10, 8'h12}) begin
      errors++;
      $display("FAIL basic_op1: got sig=%b flag=%b data=%h want 1 0 12",
               uart_signal, uart_flag, uart_rx_data);
    end
    cyc();
    rx_valid = 1'b1; rx_data = 8'h34;
    cyc();
    rx_valid = 1'b0; #1;
    checks++;
    if ({uart_signal, uart_flag, uart_rx_data, irq} !== {2'b11, 8'h34, 1'b0}) begin
      errors++;
      $display("FAIL basic_op2: got sig=%b flag=%b data=%h irq=%b want 1 1 34 0",
               uart_signal, uart_flag, uart_rx_data, irq);
    end
    cyc();
    checks++;
    if (irq !== 1'b1 || uart_signal !== 1'b0 || uart_flag !== 1'b0) begin
      errors++;
      $display("FAIL basic_irq: got irq=%b sig=%b flag=%b want 1 0 0", irq, uart_signal, uart_flag);
    end
    cyc();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL basic_irq_hold: got %b want 1", irq);
    end
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0; #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack: got irq=%b want 0", irq);
    end
  endtask

  task automatic test_wb_busy();
    wb_busy = 1'b1; rx_valid = 1'b1; rx_data = 8'h21;
    cyc();
    rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (uart_signal !== 1'b0 || uart_rx_data !== 8'h21) begin
        errors++;
        $display("FAIL busy_hold%0d: got sig=%b data=%h want 0 21", i, uart_signal, uart_rx_data);
      end
      cyc();
    end
    wb_busy = 1'b0; #1;
    checks++;
    if (uart_signal !== 1'b1 || uart_flag !== 1'b0 || uart_rx_data !== 8'h21) begin
      errors++;
      $display("FAIL busy_release: got sig=%b flag=%b data=%h want 1 0 21",
               uart_signal, uart_flag, uart_rx_data);
    end
    cyc();
    rx_valid = 1'b1; rx_data = 8'h43;
    cyc();
    rx_valid = 1'b0;
    cyc();
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
  endtask

  task automatic test_overrun();
    rx_valid = 1'b1; rx_data = 8'hBB;
    cyc();
    wb_busy = 1'b1; rx_data = 8'hAA;
    cyc();
    rx_valid = 1'b0; wb_busy = 1'b0; #1;
    checks++;
    if (rx_overrun !== 1'b1 || uart_signal !== 1'b1 || uart_rx_data !== 8'hBB) begin
      errors++;
      $display("FAIL overrun_set: got ovr=%b sig=%b data=%h want 1 1 bb",
               rx_overrun, uart_signal, uart_rx_data);
    end
    cyc();
    rx_valid = 1'b1; rx_data = 8'hCC;
    cyc();
    rx_valid = 1'b0; #1;
    checks++;
    if (uart_flag !== 1'b1 || uart_rx_data !== 8'hCC || rx_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_op2: got flag=%b data=%h ovr=%b want 1 cc 1",
               uart_flag, uart_rx_data, rx_overrun);
    end
    cyc();
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0; #1;
    checks++;
    if (rx_overrun !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got ovr=%b irq=%b want 0 0", rx_overrun, irq);
    end
  endtask

  task automatic test_timeout();
    // Byte on the 8th WAIT_OP2 cycle still lands as operand2.
    rx_valid = 1'b1; rx_data = 8'h99;
    cyc();
    rx_valid = 1'b0;
    cyc();
    for (int i = 0; i < 7; i++) cyc();
    rx_valid = 1'b1; rx_data = 8'h66;
    cyc();
    rx_valid = 1'b0; #1;
    checks++;
    if (uart_signal !== 1'b1 || uart_flag !== 1'b1 || uart_rx_data !== 8'h66) begin
      errors++;
      $display("FAIL timeout_edge: got sig=%b flag=%b data=%h want 1 1 66",
               uart_signal, uart_flag, uart_rx_data);
    end
    cyc();
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
    // No second byte: back to WAIT_OP1 after 8 cycles.
    rx_valid = 1'b1; rx_data = 8'h99;
    cyc();
    rx_valid = 1'b0;
    cyc();
    for (int i = 0; i < 8; i++) cyc();
    rx_valid = 1'b1; rx_data = 8'h56;
    cyc();
    rx_valid = 1'b0; #1;
    checks++;
    if (uart_signal !== 1'b1 || uart_flag !== 1'b0 || uart_rx_data !== 8'h56) begin
      errors++;
      $display("FAIL timeout_resync: got sig=%b flag=%b data=%h want 1 0 56",
               uart_signal, uart_flag, uart_rx_data);
    end
    cyc();
    rx_valid = 1'b1; rx_data = 8'h57;
    cyc();
    rx_valid = 1'b0;
    cyc();
    // Ack and a new byte together: next pair starts, no overrun.
    int_ack = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
    cyc();
    int_ack = 1'b0; rx_valid = 1'b0; #1;
    checks++;
    if ({uart_signal, uart_flag, uart_rx_data, rx_overrun, irq} !== {2'b10, 8'h77, 2'b00}) begin
      errors++;
      $display("FAIL ack_with_rx: got sig=%b flag=%b data=%h ovr=%b irq=%b want 1 0 77 0 0",
               uart_signal, uart_flag, uart_rx_data, rx_overrun, irq);
    end
    cyc();
    rx_valid = 1'b1; rx_data = 8'h78;
    cyc();
    rx_valid = 1'b0;
    cyc();
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0;
  endtask

  task automatic test_tx_drop();
    int starts;
    tx_ready = 1'b0;
    result_valid = 1'b1; result_data = 8'h01;
    cyc();
    result_data = 8'h02;
    cyc();
    result_valid = 1'b0; #1;
    checks++;
    if (tx_drop !== 1'b1 || tx_start !== 1'b0 || tx_data !== 8'h01) begin
      errors++;
      $display("FAIL txdrop_set: got drop=%b start=%b data=%h want 1 0 01", tx_drop, tx_start, tx_data);
    end
    tx_ready = 1'b1; #1;
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h01) begin
      errors++;
      $display("FAIL tx_launch: got start=%b data=%h want 1 01", tx_start, tx_data);
    end
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (tx_start === 1'b1) starts++;
    end
    checks++;
    if (starts != 0) begin
      errors++;
      $display("FAIL tx_single: got %0d extra starts want 0", starts);
    end
    tx_ready = 1'b0; int_ack = 1'b1;
    cyc();
    int_ack = 1'b0; #1;
    checks++;
    if (tx_drop !== 1'b0) begin
      errors++;
      $display("FAIL txdrop_clear: got %b want 0", tx_drop);
    end
  endtask

  task automatic test_back_to_back();
    result_valid = 1'b1; result_data = 8'hA1;
    cyc();
    tx_ready = 1'b1; result_data = 8'hA2; #1;
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA1) begin
      errors++;
      $display("FAIL b2b_first: got start=%b data=%h want 1 a1", tx_start, tx_data);
    end
    cyc();
    result_valid = 1'b0; #1;
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA2 || tx_drop !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got start=%b data=%h drop=%b want 1 a2 0", tx_start, tx_data, tx_drop);
    end
    cyc();
    checks++;
    if (tx_start !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: got start=%b want 0", tx_start);
    end
    // Drop event coinciding with int_ack keeps the flag set.
    tx_ready = 1'b0; result_valid = 1'b1; result_data = 8'hB1;
    cyc();
    result_data = 8'hB2; int_ack = 1'b1;
    cyc();
    result_valid = 1'b0; int_ack = 1'b0; #1;
    checks++;
    if (tx_drop !== 1'b1 || tx_data !== 8'hB1) begin
      errors++;
      $display("FAIL drop_beats_ack: got drop=%b data=%h want 1 b1", tx_drop, tx_data);
    end
    int_ack = 1'b1;
    cyc();
    int_ack = 1'b0; tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    result_valid = 1'b1; result_data = 8'h5A;
    cyc();
    result_valid = 1'b0; wb_busy = 1'b1; rx_valid = 1'b1; rx_data = 8'h11;
    cyc();
    rx_valid = 1'b0; wb_busy = 1'b0;
    cyc();
    rx_valid = 1'b1; rx_data = 8'h22; wb_busy = 1'b1;
    cyc();
    rx_valid = 1'b0; #1;
    checks++;
    if (uart_flag !== 1'b1 || tx_data !== 8'h5A) begin
      errors++;
      $display("FAIL pre_reset: got flag=%b txdata=%h want 1 5a", uart_flag, tx_data);
    end
    rst = 1'b1; #1;
    checks++;
    if ({uart_signal, uart_flag, irq, tx_start, rx_overrun, tx_drop} !== 6'b0 ||
        uart_rx_data !== 8'h00 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: got flags=%b rxd=%h txd=%h want 000000 00 00",
               {uart_signal, uart_flag, irq, tx_start, rx_overrun, tx_drop}, uart_rx_data, tx_data);
    end
    cyc();
    rst = 1'b0; wb_busy = 1'b0; tx_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (tx_start === 1'b1 || uart_signal === 1'b1) seen++;
      cyc();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL post_reset_quiet: got %0d active cycles want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wb_busy();
    test_overrun();
    test_timeout();
    test_tx_drop();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
